hc595_rx: RTL and testbench
===========================

Name: hc595_rx

Overview:
Receiving end of the 74HC595 serial display link (ds/shcp/stcp/oe). Samples the 3-wire bus in the sys_clk domain and deserializes 14-bit frames. On each storage strobe it reconstructs the 6-bit digit select and the 8-bit segment pattern. Used as an on-board link monitor, a display emulator for the slave FPGA, and a loop-back checker for the display path.

Parameters:
SYNC_STAGES, 2, synchronizer depth on ds/shcp/stcp/oe; legal values are ≥2.
TIMEOUT_CYC, 1024, sys_clk cycles without a shcp rise mid-frame before the partial frame is discarded.

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst_n  input  1  reset, asynchronous, active-low
ds  input  1  serial data from transmitter
shcp  input  1  shift clock; data sampled on its rising edge
stcp  input  1  storage strobe; frame latched on its rising edge
oe  input  1  output enable, active-low
sel  output  6  received digit select
seg  output  8  received segment pattern
blank  output  1  synchronized oe; 1 means the display is disabled
frame_vld  output  1  1-cycle pulse when a good frame is latched
frame_err  output  1  1-cycle pulse on a bad-length strobe or a timeout

Behaviour:
- Reset (asynchronous, active-low sys_rst_n, clock sys_clk):
  - sel=0, seg=0, blank=1, frame_vld=0, frame_err=0.
  - Shift register, bit counter, timeout counter and all synchronizer flops = 0.
- Synchronization:
  - ds, shcp, stcp and oe each pass through SYNC_STAGES flops, plus one history flop for shcp and stcp.
  - rise_x = synced & ~history.
  - ds takes the identical delay, so it is aligned with rise_shcp.
- Bit order and mapping:
  - Arrival index k (0..13) is stored at shreg[k].
  - shreg[0..5] map to sel[0..5].
  - shreg[6..13] map to seg[7..0], so seg[7] arrives first and seg[0] arrives last.
- Shift:
  - On rise_shcp: shreg[bit_cnt] <= ds_sync.
  - bit_cnt increments and saturates at 15. Bits beyond index 13 are not stored but are counted.
- Latch on rise_stcp:
  - If bit_cnt==14: sel/seg update from shreg and frame_vld pulses.
  - Otherwise: sel/seg hold and frame_err pulses.
  - bit_cnt clears in either case.
- Coincident rise_shcp and rise_stcp (74HC595 semantics):
  - Validation and latching use the pre-shift contents and count.
  - The new bit is then stored as index 0 of the next frame, so bit_cnt becomes 1.
- Latency: an input edge first sampled at clock edge n updates sel/seg/frame_vld/blank at edge n+SYNC_STAGES.
- Minimum input pulse width: 1 cycle for sys_clk-synchronous sources; 2 cycles for asynchronous sources.
- Timeout:
  - While bit_cnt≠0, the idle counter increments on every cycle without rise_shcp and clears on rise_shcp.
  - When it reaches TIMEOUT_CYC-1: bit_cnt and the idle counter clear, frame_err pulses, and sel/seg are unchanged.
  - Idle time with bit_cnt==0 never times out.
- rise_stcp with bit_cnt==0: frame_err pulses and outputs hold.
- blank follows oe_sync and is independent of frame state.
- Reset asserted mid-frame: all state clears immediately. The next frame must start from bit 0.

Optional Feature:
- Macro: HC595_RX_ERRCNT_EN.
- Defined:
  - Adds output err_cnt [15:0], reset 0.
  - Increments on every frame_err pulse and saturates at 16'hFFFF.
  - Clears on a frame_vld pulse only if the input err_clr (1 bit, level) is high that cycle; err_clr also clears it on its own.
- Undefined: neither port exists, no counter logic is generated, and behaviour is otherwise identical.

Test Plan:
- Good frame: drive the transmitter-pattern frame for sel=6'b111110, seg=8'hC0 (shcp period 4, ds changing 2 cycles before each shcp rise), then stcp -> sel=6'h3E, seg=8'hC0, exactly one frame_vld pulse, frame_err never high.
- Short and long frames: 13 shcp rises then stcp -> frame_err pulse, sel/seg keep their prior 6'h3E/8'hC0. Repeat with 15 rises -> same result. Then a correct 14-bit frame for sel=6'h01, seg=8'hFF -> outputs update.
- Timeout: 5 bits, then shcp idle for 1024 cycles -> one frame_err pulse and bit_cnt=0. Then a full 14-bit frame for sel=6'h20, seg=8'h5A -> frame_vld and outputs match.
- Coincident edges: after 14 bits, stcp and the next shcp rise in the same cycle -> frame latched (frame_vld). The following 13 bits plus stcp form a valid frame.
- Reset mid-frame: assert sys_rst_n low after 7 bits -> sel=0, seg=0, blank=1 asynchronously. After release, a full frame for sel=6'h15, seg=8'hA4 is received correctly.
- Streaming with HC595_RX_ERRCNT_EN: 100 back-to-back frames from a continuous 4-cycle-shcp transmitter -> 100 frame_vld pulses and err_cnt=0. Inject 3 short frames -> err_cnt=3.

Source files
------------

// File: rtl/hc595_rx.sv
// hc595_rx: receiving end of the 74HC595 serial display link.
// Samples ds/shcp/stcp/oe into sys_clk, shifts 14-bit frames and, on each
// storage strobe, rebuilds the 6-bit digit select and the 8-bit segment pattern.
// Optional build macro HC595_RX_ERRCNT_EN adds err_clr/err_cnt, a saturating
// count of frame_err pulses.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no bits received since the last strobe/timeout (bit_cnt == 0)
// ST_SHIFT | frame in progress; idle timer armed
module hc595_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        ds,
   input  logic        shcp,
   input  logic        stcp,
   input  logic        oe,
`ifdef HC595_RX_ERRCNT_EN
   input  logic        err_clr,
   output logic [15:0] err_cnt,
`endif
   output logic [5:0]  sel,
   output logic [7:0]  seg,
   output logic        blank,
   output logic        frame_vld,
   output logic        frame_err
);

   localparam int                IDLE_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
   localparam logic [3:0]        FRAME_BITS = 4'd14;
   localparam logic [3:0]        CNT_MAX    = 4'd15;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] ds_pipe;
   logic [SYNC_STAGES-1:0] shcp_pipe;
   logic [SYNC_STAGES-1:0] stcp_pipe;
   logic [SYNC_STAGES-1:0] oe_pipe;
   logic                   shcp_hist;
   logic                   stcp_hist;

   logic ds_sync;
   logic shcp_sync;
   logic stcp_sync;
   logic oe_sync;
   logic rise_shcp;
   logic rise_stcp;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        bit_cnt;
   logic [3:0]        bit_cnt_nxt;
   logic [IDLE_W-1:0] idle_cnt;
   logic [IDLE_W-1:0] idle_nxt;
   logic [13:0]       shreg;
   logic              store_en;
   logic [3:0]        store_idx;
   logic              latch_en;
   logic              err_en;
   logic [7:0]        seg_map;

   // Multi-flop synchronizers; shcp/stcp get one extra history flop for edge detect.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ds_pipe   <= '0;
         shcp_pipe <= '0;
         stcp_pipe <= '0;
         oe_pipe   <= '0;
         shcp_hist <= 1'b0;
         stcp_hist <= 1'b0;
      end else begin
         ds_pipe   <= {ds_pipe[SYNC_STAGES-2:0], ds};
         shcp_pipe <= {shcp_pipe[SYNC_STAGES-2:0], shcp};
         stcp_pipe <= {stcp_pipe[SYNC_STAGES-2:0], stcp};
         oe_pipe   <= {oe_pipe[SYNC_STAGES-2:0], oe};
         shcp_hist <= shcp_pipe[SYNC_STAGES-1];
         stcp_hist <= stcp_pipe[SYNC_STAGES-1];
      end
   end

   // ds shares the shcp delay, so ds_sync is the bit that belongs to rise_shcp.
   assign ds_sync   = ds_pipe[SYNC_STAGES-1];
   assign shcp_sync = shcp_pipe[SYNC_STAGES-1];
   assign stcp_sync = stcp_pipe[SYNC_STAGES-1];
   assign oe_sync   = oe_pipe[SYNC_STAGES-1];
   assign rise_shcp = shcp_sync & ~shcp_hist;
   assign rise_stcp = stcp_sync & ~stcp_hist;

   // Frame state, bit counter and idle timer registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         idle_cnt <= '0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         idle_cnt <= idle_nxt;
      end
   end

   // Strobe is judged on the pre-shift count; a coincident shift bit starts the next frame.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      idle_nxt    = idle_cnt;
      store_en    = 1'b0;
      store_idx   = bit_cnt;
      latch_en    = 1'b0;
      err_en      = 1'b0;

      if (rise_stcp) begin
         if (bit_cnt == FRAME_BITS) begin
            latch_en = 1'b1;
         end else begin
            err_en = 1'b1;
         end
         bit_cnt_nxt = '0;
         idle_nxt    = '0;
         state_nxt   = ST_IDLE;
      end

      if (rise_shcp) begin
         if (rise_stcp) begin
            store_idx   = '0;
            bit_cnt_nxt = 4'd1;
         end else if (bit_cnt != CNT_MAX) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
         end
         store_en  = (store_idx < FRAME_BITS);
         idle_nxt  = '0;
         state_nxt = ST_SHIFT;
      end else if (!rise_stcp && state == ST_SHIFT) begin
         if (idle_cnt == IDLE_LAST) begin
            err_en      = 1'b1;
            bit_cnt_nxt = '0;
            idle_nxt    = '0;
            state_nxt   = ST_IDLE;
         end else begin
            idle_nxt = idle_cnt + IDLE_W'(1);
         end
      end
   end

   // Shift register: arrival index k lands in shreg[k]; overflow bits are dropped.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         shreg <= '0;
      end else begin
         for (int i = 0; i < 14; i++) begin
            if (store_en && store_idx == 4'(i)) begin
               shreg[i] <= ds_sync;
            end
         end
      end
   end

   // seg[7] is the first segment bit on the wire, seg[0] the last.
   assign seg_map = {shreg[6], shreg[7], shreg[8], shreg[9],
                     shreg[10], shreg[11], shreg[12], shreg[13]};

   // Output latch, status pulses and blank.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sel       <= '0;
         seg       <= '0;
         blank     <= 1'b1;
         frame_vld <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (latch_en) begin
            sel <= shreg[5:0];
            seg <= seg_map;
         end
         blank     <= oe_sync;
         frame_vld <= latch_en;
         frame_err <= err_en;
      end
   end

`ifdef HC595_RX_ERRCNT_EN
   // Saturating error count, updated in the same cycle frame_err is raised; err_clr wins.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (err_en && err_cnt != 16'hFFFF) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hc595_rx.sv
// tb_hc595_rx: randomized bench for hc595_rx with a frame-level reference model.
// The model tracks received bits as a queue and judges strobes/timeouts by
// cycle arithmetic; a per-cycle compare process checks every output.
`timescale 1ns/1ps
module tb_hc595_rx;

   localparam int S  = 2;
   localparam int TO = 1024;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       ds        = 1'b0;
   logic       shcp      = 1'b0;
   logic       stcp      = 1'b0;
   logic       oe        = 1'b0;
   logic [5:0] sel;
   logic [7:0] seg;
   logic       blank;
   logic       frame_vld;
   logic       frame_err;
`ifdef HC595_RX_ERRCNT_EN
   logic        err_clr = 1'b0;
   logic [15:0] err_cnt;
`endif

   hc595_rx #(.SYNC_STAGES(S), .TIMEOUT_CYC(TO)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .ds        (ds),
      .shcp      (shcp),
      .stcp      (stcp),
      .oe        (oe),
`ifdef HC595_RX_ERRCNT_EN
      .err_clr   (err_clr),
      .err_cnt   (err_cnt),
`endif
      .sel       (sel),
      .seg       (seg),
      .blank     (blank),
      .frame_vld (frame_vld),
      .frame_err (frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int dut_vld_n = 0;
   int dut_err_n = 0;
   int m_vld_n = 0;

   // Reference model state
   logic [S:0] h_ds, h_shcp, h_stcp, h_oe;
   logic       rx_q[$];
   longint     cyc;
   longint     last_rise;
   logic [5:0] m_sel;
   logic [7:0] m_seg;
   logic       m_blank, m_vld, m_err;
   int         m_errcnt;

   task automatic model_reset();
      h_ds = '0; h_shcp = '0; h_stcp = '0; h_oe = '0;
      rx_q.delete();
      cyc = 0; last_rise = 0;
      m_sel = '0; m_seg = '0; m_blank = 1'b1; m_vld = 1'b0; m_err = 1'b0;
      m_errcnt = 0;
   endtask

   // One sys_clk edge: inputs reach the frame logic S edges after being sampled.
   task automatic model_step();
      logic rs, rt, d;
      rs = h_shcp[S-1] && !h_shcp[S];
      rt = h_stcp[S-1] && !h_stcp[S];
      d  = h_ds[S-1];
      cyc++;
      m_vld   = 1'b0;
      m_err   = 1'b0;
      m_blank = h_oe[S-1];
      if (rt) begin
         if (rx_q.size() == 14) begin
            m_vld = 1'b1;
            for (int k = 0; k < 6; k++) m_sel[k] = rx_q[k];
            for (int k = 6; k < 14; k++) m_seg[13-k] = rx_q[k];
         end else begin
            m_err = 1'b1;
         end
         rx_q.delete();
      end
      if (rs) begin
         rx_q.push_back(d);
         last_rise = cyc;
      end else if (!rt && rx_q.size() != 0 && (cyc - last_rise) == TO) begin
         m_err = 1'b1;
         rx_q.delete();
      end
      if (m_vld) m_vld_n++;
`ifdef HC595_RX_ERRCNT_EN
      if (err_clr) m_errcnt = 0;
      else if (m_err && m_errcnt < 65535) m_errcnt++;
`endif
      h_ds   = {h_ds[S-1:0], ds};
      h_shcp = {h_shcp[S-1:0], shcp};
      h_stcp = {h_stcp[S-1:0], stcp};
      h_oe   = {h_oe[S-1:0], oe};
   endtask

   // Compare process: model advances on posedge, outputs checked on negedge.
   initial begin
      model_reset();
      forever begin
         @(posedge sys_clk);
         if (!sys_rst_n) model_reset();
         else model_step();
         @(negedge sys_clk);
         if (!sys_rst_n) model_reset();
         n_cmp++;
         if ({sel, seg, blank, frame_vld, frame_err} !== {m_sel, m_seg, m_blank, m_vld, m_err}) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got sel=%h seg=%h blank=%b vld=%b err=%b, want sel=%h seg=%h blank=%b vld=%b err=%b",
                     $time, sel, seg, blank, frame_vld, frame_err, m_sel, m_seg, m_blank, m_vld, m_err);
         end
`ifdef HC595_RX_ERRCNT_EN
         n_cmp++;
         if (err_cnt !== 16'(m_errcnt)) begin
            n_bad++;
            $display("FAIL err_cnt t=%0t: got %0d want %0d", $time, err_cnt, m_errcnt);
         end
`endif
         if (frame_vld === 1'b1) dut_vld_n++;
         if (frame_err === 1'b1) dut_err_n++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [13:0] mk_frame(input logic [5:0] s, input logic [7:0] g);
      logic [13:0] f;
      for (int k = 0; k < 6; k++) f[k] = s[k];
      for (int k = 6; k < 14; k++) f[k] = g[13-k];
      return f;
   endfunction

   // One shcp period of 4 cycles; ds changes 2 cycles before the rise.
   task automatic send_bit(input logic b, input logic st);
      @(negedge sys_clk); shcp = 1'b0; stcp = 1'b0; ds = b;
      @(negedge sys_clk);
      @(negedge sys_clk); shcp = 1'b1; stcp = st;
      @(negedge sys_clk);
   endtask

   task automatic send_frame(input logic [5:0] s, input logic [7:0] g, input int n, input logic first_st);
      logic [13:0] f;
      f = mk_frame(s, g);
      for (int k = 0; k < n; k++)
         send_bit((k < 14) ? f[k] : 1'($urandom_range(0, 1)), (k == 0) ? first_st : 1'b0);
   endtask

   task automatic strobe();
      @(negedge sys_clk); stcp = 1'b1;
      @(negedge sys_clk);
      @(negedge sys_clk); stcp = 1'b0;
      repeat (4) @(negedge sys_clk);
      #1;
   endtask

   int          v0, e0;
   logic [5:0]  ls;
   logic [7:0]  lg;

   initial begin
      repeat (3) @(negedge sys_clk);
      #1;
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_seg", 32'(seg), 32'h0);
      chk("rst_blank", 32'(blank), 32'h1);
      chk("rst_vld_err", 32'({frame_vld, frame_err}), 32'h0);
      @(negedge sys_clk); #2 sys_rst_n = 1'b1;
      repeat (6) @(negedge sys_clk);

      // Good frame
      v0 = dut_vld_n; e0 = dut_err_n;
      send_frame(6'b111110, 8'hC0, 14, 1'b0);
      strobe();
      chk("good_sel", 32'(sel), 32'h3E);
      chk("good_seg", 32'(seg), 32'hC0);
      chk("model_sel", 32'(m_sel), 32'h3E);
      chk("good_vld_cnt", 32'(dut_vld_n - v0), 32'd1);
      chk("good_err_cnt", 32'(dut_err_n - e0), 32'd0);

      // Short and long frames
      e0 = dut_err_n;
      send_frame(6'h15, 8'h33, 13, 1'b0);
      strobe();
      chk("short_err", 32'(dut_err_n - e0), 32'd1);
      chk("short_hold", 32'({sel, seg}), 32'({6'h3E, 8'hC0}));
      e0 = dut_err_n;
      send_frame(6'h2B, 8'h77, 15, 1'b0);
      strobe();
      chk("long_err", 32'(dut_err_n - e0), 32'd1);
      chk("long_hold", 32'({sel, seg}), 32'({6'h3E, 8'hC0}));
      v0 = dut_vld_n;
      send_frame(6'h01, 8'hFF, 14, 1'b0);
      strobe();
      chk("after_bad", 32'({sel, seg}), 32'({6'h01, 8'hFF}));
      chk("after_bad_vld", 32'(dut_vld_n - v0), 32'd1);

      // Timeout
      v0 = dut_vld_n; e0 = dut_err_n;
      send_frame(6'h3F, 8'h00, 5, 1'b0);
      repeat (TO + 8) @(negedge sys_clk);
      #1;
      chk("timeout_err", 32'(dut_err_n - e0), 32'd1);
      chk("timeout_hold", 32'({sel, seg}), 32'({6'h01, 8'hFF}));
      e0 = dut_err_n;
      send_frame(6'h20, 8'h5A, 14, 1'b0);
      strobe();
      chk("post_to", 32'({sel, seg}), 32'({6'h20, 8'h5A}));
      chk("post_to_vld", 32'(dut_vld_n - v0), 32'd1);
      chk("post_to_err", 32'(dut_err_n - e0), 32'd0);

      // Coincident strobe and shift edge
      v0 = dut_vld_n; e0 = dut_err_n;
      send_frame(6'h0F, 8'h81, 14, 1'b0);
      send_frame(6'h2A, 8'h3C, 14, 1'b1);
      strobe();
      chk("coinc_vld", 32'(dut_vld_n - v0), 32'd2);
      chk("coinc_err", 32'(dut_err_n - e0), 32'd0);
      chk("coinc_out", 32'({sel, seg}), 32'({6'h2A, 8'h3C}));

      // Reset mid-frame
      send_frame(6'h11, 8'h22, 7, 1'b0);
      @(negedge sys_clk); #2 sys_rst_n = 1'b0;
      #1;
      chk("arst_out", 32'({sel, seg}), 32'h0);
      chk("arst_blank", 32'(blank), 32'h1);
      shcp = 1'b0; stcp = 1'b0;
      repeat (2) @(negedge sys_clk);
      #2 sys_rst_n = 1'b1;
      repeat (4) @(negedge sys_clk);
      v0 = dut_vld_n;
      send_frame(6'h15, 8'hA4, 14, 1'b0);
      strobe();
      chk("post_rst", 32'({sel, seg}), 32'({6'h15, 8'hA4}));
      chk("post_rst_vld", 32'(dut_vld_n - v0), 32'd1);

      // Streaming: continuous shcp, each strobe coincides with the next frame's first bit
`ifdef HC595_RX_ERRCNT_EN
      @(negedge sys_clk); err_clr = 1'b1;
      @(negedge sys_clk); err_clr = 1'b0;
`endif
      v0 = dut_vld_n; e0 = dut_err_n;
      ls = '0; lg = '0;
      for (int f = 0; f < 100; f++) begin
         ls = 6'($urandom); lg = 8'($urandom);
         send_frame(ls, lg, 14, (f > 0));
      end
      strobe();
      chk("stream_vld", 32'(dut_vld_n - v0), 32'd100);
      chk("stream_err", 32'(dut_err_n - e0), 32'd0);
      chk("stream_last", 32'({sel, seg}), 32'({ls, lg}));
`ifdef HC595_RX_ERRCNT_EN
      chk("stream_errcnt", 32'(err_cnt), 32'd0);
`endif
      e0 = dut_err_n;
      for (int i = 0; i < 3; i++) begin
         send_frame(6'($urandom), 8'($urandom), 6 + i, 1'b0);
         strobe();
      end
      chk("inject_err", 32'(dut_err_n - e0), 32'd3);
      chk("inject_hold", 32'({sel, seg}), 32'({ls, lg}));
`ifdef HC595_RX_ERRCNT_EN
      chk("inject_errcnt", 32'(err_cnt), 32'd3);
`endif

      // Randomized traffic against the model
      for (int it = 0; it < 60; it++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if ($urandom_range(0, 3) == 0) oe = 1'($urandom_range(0, 1));
`ifdef HC595_RX_ERRCNT_EN
         if ($urandom_range(0, 9) == 0) begin
            @(negedge sys_clk); err_clr = 1'b1;
            @(negedge sys_clk); err_clr = 1'b0;
         end
`endif
         if (kind <= 6) begin
            send_frame(6'($urandom), 8'($urandom), 14, 1'b0);
            strobe();
         end else if (kind <= 8) begin
            send_frame(6'($urandom), 8'($urandom), $urandom_range(1, 17), 1'($urandom_range(0, 1)));
            strobe();
         end else begin
            send_frame(6'($urandom), 8'($urandom), 14, 1'b0);
            send_frame(6'($urandom), 8'($urandom), 14, 1'b1);
            strobe();
         end
         repeat ($urandom_range(0, 6)) @(negedge sys_clk);
      end
      repeat (4) @(negedge sys_clk);
      #1;
      chk("vld_total", 32'(dut_vld_n), 32'(m_vld_n));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
